gf163_reduce: RTL and testbench

Sequential modular reducer placed directly downstream of the 163-bit overlap-free Karatsuba multiplier. It accepts the raw 325-bit GF(2)[x] product and reduces it modulo the NIST B-163 pentanomial f(x) = x^163 + x^7 + x^6 + x^3 + 1. The output is a 163-bit field element. Valid/ready handshakes sit on both sides, so the block can be placed between the combinational multiplier and the point-arithmetic datapath.

---
 rtl/gf163_reduce.sv | 111 +++++++++++
 tb/tb_gf163_reduce.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gf163_reduce.sv
// Two-fold sequential reducer of a 325-bit GF(2)[x] product modulo x^163+x^7+x^6+x^3+1.
// Optional handshake counter red_count is enabled by defining GF163_REDUCE_STATS_EN.
module gf163_reduce #(
   parameter int             M        = 163,
   parameter logic [M-1:0]   POLY_LOW = 163'h0C9,
   parameter int             TAP_DEG  = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*M-2:0]   in_prod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [M-1:0]     out_elem
`ifdef GF163_REDUCE_STATS_EN
   ,
   output logic [31:0]      red_count
`endif
);

   localparam int H_W  = M - 1;
   localparam int R1_W = M + TAP_DEG - 1;
   localparam int G_W  = TAP_DEG - 1;

   typedef enum logic [1:0] {IDLE, FOLD1, FOLD2, DONE} state_t;

   state_t               state_reg;
   logic [2*M-2:0]       c_reg;
   logic [R1_W-1:0]      r1_reg;

   logic [H_W-1:0]       h;
   logic [M-1:0]         l;
   logic [G_W-1:0]       g;
   logic [R1_W-1:0]      fold1_next;
   logic [M-1:0]         fold2_next;
   logic [R1_W-1:0]      pp1 [TAP_DEG+1];
   logic [M-1:0]         pp2 [TAP_DEG+1];

   assign h = c_reg[2*M-2:M];
   assign l = c_reg[M-1:0];
   assign g = r1_reg[R1_W-1:M];

   // Multiplying by POLY_LOW is one shifted copy of the high part per set tap.
   for (genvar gi = 0; gi <= TAP_DEG; gi++) begin : g_taps
      assign pp1[gi] = POLY_LOW[gi] ? (R1_W'(h) << gi) : '0;
      assign pp2[gi] = POLY_LOW[gi] ? (M'(g) << gi) : '0;
   end

   always_comb begin
      fold1_next = R1_W'(l);
      fold2_next = r1_reg[M-1:0];
      for (int j = 0; j <= TAP_DEG; j++) begin
         fold1_next = fold1_next ^ pp1[j];
         fold2_next = fold2_next ^ pp2[j];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_elem  <= '0;
         c_reg     <= '0;
         r1_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  c_reg     <= in_prod;
                  in_ready  <= 1'b0;
                  state_reg <= FOLD1;
               end
            end
            FOLD1: begin
               r1_reg    <= fold1_next;
               state_reg <= FOLD2;
            end
            FOLD2: begin
               out_elem  <= fold2_next;
               out_valid <= 1'b1;
               state_reg <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef GF163_REDUCE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         red_count <= '0;
      end else if (state_reg == DONE && out_ready) begin
         red_count <= red_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gf163_reduce.sv
// Directed + random bench for gf163_reduce against a long-division reference reducer.
// Also checks red_count when GF163_REDUCE_STATS_EN is defined.
module tb_gf163_reduce;

   localparam int M = 163;
   localparam logic [2*M-2:0] F_POLY = (325'd1 << 163) | 325'h0C9;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2*M-2:0]   in_prod = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [M-1:0]     out_elem;
`ifdef GF163_REDUCE_STATS_EN
   logic [31:0]      red_count;
`endif
   logic [31:0]      exp_count = 32'd0;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   gf163_reduce dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_elem  (out_elem)
`ifdef GF163_REDUCE_STATS_EN
      ,
      .red_count (red_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input string what,
                        input logic [324:0] obs, input logic [324:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s.%s: observed %h expected %h", tag, what, obs, exp);
   endtask

   // Schoolbook long division by f(x), one leading bit at a time.
   function automatic logic [M-1:0] ref_reduce(input logic [324:0] c);
      logic [324:0] r;
      r = c;
      for (int i = 324; i >= M; i--)
         if (r[i]) r = r ^ (F_POLY << (i - M));
      return r[M-1:0];
   endfunction

   function automatic logic [324:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [324:0] r;
      r = '0;
      for (int i = 0; i < M; i++)
         if (b[i]) r = r ^ (325'(a) << i);
      return r;
   endfunction

   function automatic logic [M-1:0] rand163();
      logic [191:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[M-1:0];
   endfunction

   function automatic logic [324:0] rand325();
      logic [351:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[324:0];
   endfunction

   task automatic check_count(input string tag);
`ifdef GF163_REDUCE_STATS_EN
      check(tag, "red_count", red_count, exp_count);
`endif
   endtask

   // One full transaction with out_ready held high throughout.
   task automatic run_op(input string tag, input logic [324:0] prod, input logic [M-1:0] exp);
      out_ready = 1'b1;
      check(tag, "idle_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      in_prod  = prod;
      tick();
      in_valid = 1'b0;
      in_prod  = rand325();
      check(tag, "busy_ready", in_ready, 1'b0);
      check(tag, "early_valid", out_valid, 1'b0);
      tick();
      tick();
      check(tag, "valid", out_valid, 1'b1);
      check(tag, "elem", out_elem, exp);
      tick();
      exp_count = exp_count + 32'd1;
      check(tag, "drop_valid", out_valid, 1'b0);
      check(tag, "back_ready", in_ready, 1'b1);
      check_count(tag);
      $display("op %s prod=%h res=%h", tag, prod, out_elem);
   endtask

   initial begin
      logic [324:0] p;
      logic [M-1:0] a, b, e;

      // Reset held for two cycles, then idle.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset", "in_ready", in_ready, 1'b1);
      check("reset", "out_valid", out_valid, 1'b0);
      check("reset", "out_elem", out_elem, '0);
      check_count("reset");
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle", "in_ready", in_ready, 1'b1);
         check("idle", "out_valid", out_valid, 1'b0);
      end

      run_op("x163", 325'd1 << 163, 163'h0C9);
      run_op("x324", 325'd1 << 324, (163'd1 << 161) | 163'h1422);
      run_op("pass5", 325'h5, 163'h5);
      run_op("zero", '0, '0);
      p = '1;
      run_op("ones", p, ref_reduce(p));

      // Backpressure with in_valid pulsed in every busy state.
      p = rand325();
      e = ref_reduce(p);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_prod   = p;
      tick();
      in_prod = rand325();
      check("bp", "fold1_ready", in_ready, 1'b0);
      tick();
      in_prod = rand325();
      check("bp", "fold2_ready", in_ready, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) begin
         in_prod = rand325();
         check("bp", "hold_valid", out_valid, 1'b1);
         check("bp", "hold_elem", out_elem, e);
         check("bp", "hold_ready", in_ready, 1'b0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      exp_count = exp_count + 32'd1;
      check("bp", "drop_valid", out_valid, 1'b0);
      check("bp", "back_ready", in_ready, 1'b1);
      check_count("bp");
      tick();
      check("bp", "single_result", out_valid, 1'b0);
      check_count("bp_after");
      $display("op bp prod=%h res=%h", p, e);

      // Reset asserted during FOLD2 discards the product.
      in_valid = 1'b1;
      in_prod  = rand325();
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_count = 32'd0;
      check("midrst", "out_valid", out_valid, 1'b0);
      check("midrst", "in_ready", in_ready, 1'b1);
      check("midrst", "out_elem", out_elem, '0);
      check_count("midrst");
      tick();
      tick();
      check("midrst", "stay_idle", out_valid, 1'b0);
      $display("op midrst discarded");

      a = 163'hABABABABAB;
      b = 163'hFAAFD57EABF55FAAFD57;
      p = clmul(a, b);
      run_op("named", p, ref_reduce(p));

      for (int n = 0; n < 1000; n++) begin
         a = rand163();
         b = rand163();
         p = clmul(a, b);
         run_op("rand", p, ref_reduce(p));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
